output_buffer: RTL and testbench

//  CPU-to-IO store path; the write-side counterpart of the IO load buffer.
//  - Stores (sb/sh/sw, selected by funct3) merge into a 32-bit shadow register at the given byte offset.
//  - Every accepted store pushes the merged word into a FIFO.
//  - The FIFO drains to the external device over a valid/ready handshake.
//  - stall tells the CPU to hold the store while the FIFO is full.

---
 rtl/output_buffer_if.sv | 28 ++
 rtl/output_buffer.sv | 84 ++++++++
 tb/tb_output_buffer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/output_buffer_if.sv
// Store-path bundle between the CPU/device side and the output buffer.
// The slave modport is the buffer; the master modport is the CPU and IO device.
interface output_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH + 1);

  logic          write;
  logic [2:0]    data_type;
  logic [1:0]    data_offset;
  logic [31:0]   cpu_in;
  logic          stall;
  logic [31:0]   shadow_out;
  logic [31:0]   io_out;
  logic          io_valid;
  logic          io_ready;
  logic [LW-1:0] level;

  modport slave (
    input  write, data_type, data_offset, cpu_in, io_ready,
    output stall, shadow_out, io_out, io_valid, level
  );

  modport master (
    output write, data_type, data_offset, cpu_in, io_ready,
    input  stall, shadow_out, io_out, io_valid, level
  );
endinterface

// File: rtl/output_buffer.sv
// CPU-to-IO store path: byte/half/word stores merge into a shadow word and
// every accepted store queues the merged word for a valid/ready IO drain.
module output_buffer #(
  parameter int DEPTH = 4
) (
  input logic           clock,
  input logic           reset,
  output_buffer_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   merged;
  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          full, empty, push, pop;
  logic          unused_dt2;

  // funct3 bit 2 only distinguishes signed/unsigned loads; stores ignore it
  assign unused_dt2 = bus.data_type[2];

  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == '0);
  // stall comes from the registered count alone, so a same-cycle pop never admits a push
  assign push  = bus.write && !full;
  assign pop   = !empty && bus.io_ready;

  always_comb begin
    merged = shadow_q;
    case (bus.data_type[1:0])
      2'b00:   merged[{bus.data_offset, 3'b000} +: 8]     = bus.cpu_in[7:0];
      2'b01:   merged[{bus.data_offset[1], 4'b0000} +: 16] = bus.cpu_in[15:0];
      default: merged = bus.cpu_in;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      shadow_d = merged;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + LW'(1);
    end else if (!push && pop) begin
      count_d = count_q - LW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= merged;
    end
  end

  assign bus.stall      = full;
  assign bus.shadow_out = shadow_q;
  assign bus.io_valid   = !empty;
  assign bus.io_out     = empty ? 32'h0 : mem_q[rd_ptr_q];
  assign bus.level      = count_q;
endmodule

// File: tb/tb_output_buffer.sv
// Scoreboard bench for output_buffer: directed scenarios followed by random
// traffic, checked against a byte-lane reference model and a word queue.
module tb_output_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_buffer_if #(.DEPTH(DEPTH)) bus ();
  output_buffer #(.DEPTH(DEPTH)) dut (.clock(clk), .reset(rst), .bus(bus));

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  logic [31:0] m_shadow = 32'h0;
  bit          mon_en = 1'b0;
  logic [31:0] words[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_merge(input logic [31:0] sh, input logic [2:0] t,
                                            input logic [1:0] off, input logic [31:0] d);
    logic [7:0] b[4];
    int base;
    for (int i = 0; i < 4; i++) b[i] = sh[8*i +: 8];
    case (int'(t) % 4)
      0: b[int'(off)] = d[7:0];
      1: begin
        base = int'(off) & 2;
        b[base]     = d[7:0];
        b[base + 1] = d[15:8];
      end
      default: for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
    endcase
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Called at a negedge; drives one cycle of stimulus and returns at the next negedge.
  task automatic step(input bit w, input logic [2:0] t, input logic [1:0] off,
                      input logic [31:0] d, input bit rdy);
    bit acc;
    logic [31:0] mw;
    bus.write       = w;
    bus.data_type   = t;
    bus.data_offset = off;
    bus.cpu_in      = d;
    bus.io_ready    = rdy;
    chk("level", 32'(bus.level), 32'(sb_q.size()));
    chk("stall", 32'(bus.stall), (sb_q.size() == DEPTH) ? 32'd1 : 32'd0);
    chk("shadow", bus.shadow_out, m_shadow);
    acc = w && (sb_q.size() < DEPTH);
    mw  = ref_merge(m_shadow, t, off, d);
    @(posedge clk);
    #1;
    if (acc) begin
      sb_q.push_back(mw);
      m_shadow = mw;
    end
    bus.write = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles, input bit w);
    rst             = 1'b1;
    bus.write       = w;
    bus.io_ready    = 1'b0;
    bus.data_type   = 3'b010;
    bus.data_offset = 2'b00;
    bus.cpu_in      = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    sb_q.delete();
    m_shadow = 32'h0;
    repeat (cycles - 1) @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.write = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: compares the presented head against the scoreboard and retires it on a handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        chk("io_valid", 32'(bus.io_valid), (sb_q.size() != 0) ? 32'd1 : 32'd0);
        if (sb_q.size() != 0) begin
          chk("io_out", bus.io_out, sb_q[0]);
          if (bus.io_ready) void'(sb_q.pop_front());
        end else begin
          chk("io_out_idle", bus.io_out, 32'h0);
        end
      end
    end
  end

  initial begin
    rst             = 1'b1;
    bus.write       = 1'b0;
    bus.data_type   = 3'b000;
    bus.data_offset = 2'b00;
    bus.cpu_in      = 32'h0;
    bus.io_ready    = 1'b0;
    words[0] = 32'hA1A1_0001;
    words[1] = 32'hB2B2_0002;
    words[2] = 32'hC3C3_0003;
    words[3] = 32'hD4D4_0004;
    @(negedge clk);
    do_reset(2, 1'b0);
    mon_en = 1'b1;

    chk("rst_shadow", bus.shadow_out, 32'h0);
    chk("rst_valid", 32'(bus.io_valid), 32'd0);
    chk("rst_io_out", bus.io_out, 32'h0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);

    step(1'b1, 3'b000, 2'd2, 32'h0000_00AB, 1'b0);
    chk("sb_shadow", bus.shadow_out, 32'h00AB_0000);
    chk("sb_io_out", bus.io_out, 32'h00AB_0000);
    chk("sb_valid", 32'(bus.io_valid), 32'd1);
    step(1'b0, 3'b000, 2'd0, 32'h0, 1'b1);
    do_reset(1, 1'b0);

    step(1'b1, 3'b010, 2'd3, 32'h1122_3344, 1'b1);
    chk("merge_sw", bus.io_out, 32'h1122_3344);
    step(1'b1, 3'b001, 2'd3, 32'h0000_BEEF, 1'b1);
    chk("merge_sh", bus.io_out, 32'hBEEF_3344);
    step(1'b1, 3'b100, 2'd0, 32'h0000_0055, 1'b1);
    chk("merge_sb", bus.io_out, 32'hBEEF_3355);
    step(1'b0, 3'b000, 2'd0, 32'h0, 1'b1);
    chk("merge_drained", 32'(bus.level), 32'd0);

    do_reset(1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 3'b010, 2'd0, words[i], 1'b0);
    chk("full_level", 32'(bus.level), 32'd4);
    chk("full_stall", 32'(bus.stall), 32'd1);
    step(1'b1, 3'b010, 2'd0, 32'h0000_DEAD, 1'b0);
    chk("drop_shadow", bus.shadow_out, words[3]);
    chk("drop_level", 32'(bus.level), 32'd4);
    step(1'b0, 3'b000, 2'd0, 32'h0, 1'b1);
    chk("pop1_level", 32'(bus.level), 32'd3);
    chk("pop1_stall", 32'(bus.stall), 32'd0);
    chk("pop1_head", bus.io_out, words[1]);

    step(1'b0, 3'b000, 2'd0, 32'h0, 1'b1);
    step(1'b1, 3'b010, 2'd0, 32'h5A5A_0005, 1'b1);
    chk("pushpop_level", 32'(bus.level), 32'd2);
    chk("pushpop_head", bus.io_out, words[3]);
    step(1'b1, 3'b010, 2'd0, 32'h6B6B_0006, 1'b0);
    step(1'b1, 3'b010, 2'd0, 32'h7C7C_0007, 1'b0);
    chk("refill_level", 32'(bus.level), 32'd4);
    step(1'b1, 3'b010, 2'd0, 32'h0000_0077, 1'b1);
    chk("fullpop_level", 32'(bus.level), 32'd3);
    chk("fullpop_shadow", bus.shadow_out, 32'h7C7C_0007);

    chk("pre_rst_valid", 32'(bus.io_valid), 32'd1);
    do_reset(1, 1'b1);
    chk("midrst_level", 32'(bus.level), 32'd0);
    chk("midrst_valid", 32'(bus.io_valid), 32'd0);
    chk("midrst_shadow", bus.shadow_out, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1, 1'($urandom_range(0, 1)));
      end else begin
        step(($urandom_range(0, 99) < 60), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             $urandom, ($urandom_range(0, 99) < 45));
      end
    end
    for (int n = 0; n < DEPTH + 1; n++) step(1'b0, 3'b000, 2'd0, 32'h0, 1'b1);
    chk("final_empty", 32'(bus.level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
